// File: rtl/ex_pkg.sv
// ex_pkg: shared encodings for the execute stage and its multiply/divide unit
package ex_pkg;
  localparam logic [2:0] MD_NONE  = 3'b000;
  localparam logic [2:0] MD_MULT  = 3'b001;
  localparam logic [2:0] MD_MULTU = 3'b010;
  localparam logic [2:0] MD_DIV   = 3'b011;
  localparam logic [2:0] MD_DIVU  = 3'b100;
  localparam logic [2:0] MD_MTHI  = 3'b101;
  localparam logic [2:0] MD_MTLO  = 3'b110;
  localparam logic [1:0] HL_ALU = 2'b00;
  localparam logic [1:0] HL_HI  = 2'b01;
  localparam logic [1:0] HL_LO  = 2'b10;
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_AND  = 2;
  localparam int ALU_OR   = 3;
  localparam int ALU_XOR  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_SLL  = 6;
  localparam int ALU_SRL  = 7;
  localparam int ALU_SRA  = 8;
  localparam int ALU_SLT  = 9;
  localparam int ALU_SLTU = 10;
  localparam int ALU_LUI  = 11;
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} md_state_t;
endpackage

// File: rtl/alu.sv
// alu: combinational integer ALU; shifts take their amount from operand a
module alu
  import ex_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ALUCODE_W = 5
) (
  input  logic [ALUCODE_W-1:0] code,
  input  logic [DATA_W-1:0]    a,
  input  logic [DATA_W-1:0]    b,
  output logic [DATA_W-1:0]    result
);
  localparam int SW = $clog2(DATA_W);
  logic [SW-1:0] sa;
  assign sa = a[SW-1:0];
  always_comb
    case (code)
      ALUCODE_W'(ALU_ADD):  result = a + b;
      ALUCODE_W'(ALU_SUB):  result = a - b;
      ALUCODE_W'(ALU_AND):  result = a & b;
      ALUCODE_W'(ALU_OR):   result = a | b;
      ALUCODE_W'(ALU_XOR):  result = a ^ b;
      ALUCODE_W'(ALU_NOR):  result = ~(a | b);
      ALUCODE_W'(ALU_SLL):  result = b << sa;
      ALUCODE_W'(ALU_SRL):  result = b >> sa;
      ALUCODE_W'(ALU_SRA):  result = $signed(b) >>> sa;
      ALUCODE_W'(ALU_SLT):  result = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
      ALUCODE_W'(ALU_SLTU): result = {{(DATA_W-1){1'b0}}, a < b};
      ALUCODE_W'(ALU_LUI):  result = b << (DATA_W / 2);
      default:              result = a + b;
    endcase
endmodule

// File: rtl/md_unit.sv
// md_unit: iterative multiply/divide on magnitudes with sign fix-up, owning HI/LO
module md_unit
  import ex_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);
  localparam int CW = $clog2(DATA_W);
  md_state_t state;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] acc, sh, opb, quo, rem;
  logic neg_q, neg_r, dz, div_op;
  logic go, is_mul, is_div, sgn, a_neg, b_neg;
  logic [DATA_W:0] sum, dif;
  logic [2*DATA_W-1:0] prod;
  assign busy = state != IDLE;
  assign go = start && !busy;
  assign is_mul = op == MD_MULT || op == MD_MULTU;
  assign is_div = op == MD_DIV || op == MD_DIVU;
  assign sgn = op == MD_MULT || op == MD_DIV;
  assign a_neg = sgn && a[DATA_W-1];
  assign b_neg = sgn && b[DATA_W-1];
  // acc holds the high half / partial remainder, sh the multiplier / dividend-then-quotient
  assign sum = {1'b0, acc} + (sh[0] ? {1'b0, opb} : '0);
  assign dif = {acc, sh[DATA_W-1]} - {1'b0, opb};
  assign prod = neg_q ? -{acc, sh} : {acc, sh};
  assign quo = dz ? '1 : neg_q ? -sh : sh;
  assign rem = neg_r ? -acc : acc;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      sh <= '0;
      opb <= '0;
      hi <= '0;
      lo <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
      div_op <= 1'b0;
    end else
      case (state)
        IDLE: begin
          if (go && (is_mul || is_div)) begin
            state <= is_mul ? MUL : DIV;
            cnt <= CW'(DATA_W - 1);
            acc <= '0;
            sh <= a_neg ? -a : a;
            opb <= b_neg ? -b : b;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            dz <= is_div && b == '0;
            div_op <= is_div;
          end
          if (go && op == MD_MTHI) hi <= a;
          if (go && op == MD_MTLO) lo <= a;
        end
        MUL: begin
          acc <= sum[DATA_W:1];
          sh <= {sum[0], sh[DATA_W-1:1]};
          cnt <= cnt - CW'(1);
          if (cnt == '0) state <= FIX;
        end
        DIV: begin
          acc <= dif[DATA_W] ? {acc[DATA_W-2:0], sh[DATA_W-1]} : dif[DATA_W-1:0];
          sh <= {sh[DATA_W-2:0], !dif[DATA_W]};
          cnt <= cnt - CW'(1);
          if (cnt == '0) state <= FIX;
        end
        default: begin
          {hi, lo} <= div_op ? {rem, quo} : prod;
          state <= IDLE;
        end
      endcase
endmodule

// File: rtl/ex_stage_md.sv
// ex_stage_md: MIPS execute stage with MEM/WB forwarding and a stalling multiply/divide unit
module ex_stage_md
  import ex_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int ALUCODE_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Valid_ex,
  input  logic                 RegDst_ex,
  input  logic                 ALUSrcA_ex,
  input  logic                 ALUSrcB_ex,
  input  logic [ALUCODE_W-1:0] ALUCode_ex,
  input  logic [2:0]           MDOp_ex,
  input  logic [1:0]           HiLoRd_ex,
  input  logic [DATA_W-1:0]    Imm_ex,
  input  logic [DATA_W-1:0]    Sa_ex,
  input  logic [DATA_W-1:0]    RsData_ex,
  input  logic [DATA_W-1:0]    RtData_ex,
  input  logic [REG_AW-1:0]    RsAddr_ex,
  input  logic [REG_AW-1:0]    RtAddr_ex,
  input  logic [REG_AW-1:0]    RdAddr_ex,
  input  logic [DATA_W-1:0]    ALUResult_mem,
  input  logic [DATA_W-1:0]    RegWriteData_wb,
  input  logic [REG_AW-1:0]    RegWriteAddr_mem,
  input  logic [REG_AW-1:0]    RegWriteAddr_wb,
  input  logic                 RegWrite_mem,
  input  logic                 RegWrite_wb,
  output logic [REG_AW-1:0]    RegWriteAddr_ex,
  output logic [DATA_W-1:0]    ALUResult_ex,
  output logic [DATA_W-1:0]    MemWriteData_ex,
  output logic [DATA_W-1:0]    ALU_A,
  output logic [DATA_W-1:0]    ALU_B,
  output logic                 MDBusy,
  output logic                 Stall_ex
);
  logic mem_ok, wb_ok;
  logic [DATA_W-1:0] rs_fwd, rt_fwd, hi, lo, alu_res;
  assign mem_ok = RegWrite_mem && RegWriteAddr_mem != '0;
  assign wb_ok = RegWrite_wb && RegWriteAddr_wb != '0;
  // MEM is tested first so it wins over WB when both target the same register
  assign rs_fwd = mem_ok && RegWriteAddr_mem == RsAddr_ex ? ALUResult_mem :
                  wb_ok && RegWriteAddr_wb == RsAddr_ex ? RegWriteData_wb : RsData_ex;
  assign rt_fwd = mem_ok && RegWriteAddr_mem == RtAddr_ex ? ALUResult_mem :
                  wb_ok && RegWriteAddr_wb == RtAddr_ex ? RegWriteData_wb : RtData_ex;
  assign ALU_A = ALUSrcA_ex ? Sa_ex : rs_fwd;
  assign ALU_B = ALUSrcB_ex ? Imm_ex : rt_fwd;
  assign MemWriteData_ex = rt_fwd;
  assign RegWriteAddr_ex = RegDst_ex ? RdAddr_ex : RtAddr_ex;
  assign ALUResult_ex = Valid_ex && HiLoRd_ex == HL_HI ? hi :
                        Valid_ex && HiLoRd_ex == HL_LO ? lo : alu_res;
  assign Stall_ex = Valid_ex && MDBusy && (MDOp_ex != MD_NONE || HiLoRd_ex != HL_ALU);
  alu #(.DATA_W(DATA_W), .ALUCODE_W(ALUCODE_W)) u_alu (
    .code(ALUCode_ex),
    .a(ALU_A),
    .b(ALU_B),
    .result(alu_res)
  );
  md_unit #(.DATA_W(DATA_W)) u_md (
    .clk(clk),
    .rst(reset),
    .start(Valid_ex),
    .op(MDOp_ex),
    .a(rs_fwd),
    .b(rt_fwd),
    .busy(MDBusy),
    .hi(hi),
    .lo(lo)
  );
endmodule

// File: tb/tb_ex_stage_md.sv
// tb_ex_stage_md: directed checks of forwarding, MD results, stall timing and async reset
module tb_ex_stage_md;
  import ex_pkg::*;
  logic clk = 1'b0, reset = 1'b1;
  logic Valid_ex, RegDst_ex, ALUSrcA_ex, ALUSrcB_ex, RegWrite_mem, RegWrite_wb;
  logic [4:0] ALUCode_ex, RsAddr_ex, RtAddr_ex, RdAddr_ex, RegWriteAddr_mem, RegWriteAddr_wb, RegWriteAddr_ex;
  logic [2:0] MDOp_ex;
  logic [1:0] HiLoRd_ex;
  logic [31:0] Imm_ex, Sa_ex, RsData_ex, RtData_ex, ALUResult_mem, RegWriteData_wb;
  logic [31:0] ALUResult_ex, MemWriteData_ex, ALU_A, ALU_B;
  logic MDBusy, Stall_ex;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  ex_stage_md dut (
    .clk(clk), .reset(reset), .Valid_ex(Valid_ex), .RegDst_ex(RegDst_ex),
    .ALUSrcA_ex(ALUSrcA_ex), .ALUSrcB_ex(ALUSrcB_ex), .ALUCode_ex(ALUCode_ex),
    .MDOp_ex(MDOp_ex), .HiLoRd_ex(HiLoRd_ex), .Imm_ex(Imm_ex), .Sa_ex(Sa_ex),
    .RsData_ex(RsData_ex), .RtData_ex(RtData_ex), .RsAddr_ex(RsAddr_ex),
    .RtAddr_ex(RtAddr_ex), .RdAddr_ex(RdAddr_ex), .ALUResult_mem(ALUResult_mem),
    .RegWriteData_wb(RegWriteData_wb), .RegWriteAddr_mem(RegWriteAddr_mem),
    .RegWriteAddr_wb(RegWriteAddr_wb), .RegWrite_mem(RegWrite_mem),
    .RegWrite_wb(RegWrite_wb), .RegWriteAddr_ex(RegWriteAddr_ex),
    .ALUResult_ex(ALUResult_ex), .MemWriteData_ex(MemWriteData_ex),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .MDBusy(MDBusy), .Stall_ex(Stall_ex)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic rd(input logic [1:0] sel, input string tag, input logic [31:0] exp);
    MDOp_ex = MD_NONE;
    HiLoRd_ex = sel;
    #1 chk(tag, ALUResult_ex, exp);
  endtask
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    MDOp_ex = op;
    HiLoRd_ex = HL_ALU;
    RsData_ex = a;
    RtData_ex = b;
    step;
    MDOp_ex = MD_NONE;
  endtask
  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    MDOp_ex = MD_NONE;
    HiLoRd_ex = HL_ALU;
    #1;
    while (MDBusy && n < 100) begin
      step;
      n++;
    end
    chk(tag, MDBusy, 1'b0);
  endtask
  initial begin
    int n;
    Valid_ex = 1'b1; RegDst_ex = 1'b0; ALUSrcA_ex = 1'b0; ALUSrcB_ex = 1'b0;
    ALUCode_ex = 5'(ALU_ADD); MDOp_ex = MD_NONE; HiLoRd_ex = HL_LO;
    Imm_ex = '0; Sa_ex = '0; RsData_ex = '0; RtData_ex = '0;
    RsAddr_ex = 5'd1; RtAddr_ex = 5'd2; RdAddr_ex = 5'd3;
    ALUResult_mem = '0; RegWriteData_wb = '0; RegWriteAddr_mem = '0; RegWriteAddr_wb = '0;
    RegWrite_mem = 1'b0; RegWrite_wb = 1'b0;
    step;
    step;
    chk("rst_busy", MDBusy, 1'b0);
    chk("rst_stall", Stall_ex, 1'b0);
    chk("rst_lo", ALUResult_ex, 32'h0);
    reset = 1'b0;
    rd(HL_HI, "rst_hi", 32'h0);
    step;
    HiLoRd_ex = HL_ALU;
    RsAddr_ex = 5'd8; RtAddr_ex = 5'd8; RsData_ex = 32'hAA; RtData_ex = 32'hBB;
    RegWrite_mem = 1'b1; RegWriteAddr_mem = 5'd8; ALUResult_mem = 32'h11;
    RegWrite_wb = 1'b1; RegWriteAddr_wb = 5'd8; RegWriteData_wb = 32'h22;
    #1 chk("fwd_a", ALU_A, 32'h11);
    chk("fwd_b", ALU_B, 32'h11);
    chk("fwd_mwd", MemWriteData_ex, 32'h11);
    chk("fwd_add", ALUResult_ex, 32'h22);
    RegWrite_mem = 1'b0;
    #1 chk("fwd_wb_a", ALU_A, 32'h22);
    RegWrite_mem = 1'b1;
    RsAddr_ex = 5'd0; RtAddr_ex = 5'd0; RegWriteAddr_mem = 5'd0; RegWriteAddr_wb = 5'd0;
    #1 chk("r0_a", ALU_A, 32'hAA);
    chk("r0_b", ALU_B, 32'hBB);
    step;
    ALUCode_ex = 5'(ALU_SUB);
    #1 chk("sub", ALUResult_ex, 32'hFFFFFFEF);
    ALUCode_ex = 5'(ALU_ADD);
    ALUSrcA_ex = 1'b1; Sa_ex = 32'd4; ALUSrcB_ex = 1'b1; Imm_ex = 32'h100;
    #1 chk("src_a", ALU_A, 32'd4);
    chk("src_imm_add", ALUResult_ex, 32'h104);
    RegDst_ex = 1'b1;
    #1 chk("dst_rd", RegWriteAddr_ex, 5'd3);
    RegDst_ex = 1'b0; RtAddr_ex = 5'd9;
    #1 chk("dst_rt", RegWriteAddr_ex, 5'd9);
    step;
    ALUSrcA_ex = 1'b0; ALUSrcB_ex = 1'b0; RegWrite_mem = 1'b0; RegWrite_wb = 1'b0;
    RsAddr_ex = 5'd1; RtAddr_ex = 5'd2;
    MDOp_ex = MD_MULT; RsData_ex = 32'hFFFFFFFD; RtData_ex = 32'd7;
    #1 chk("mul_start_nostall", Stall_ex, 1'b0);
    step;
    MDOp_ex = MD_NONE; HiLoRd_ex = HL_LO;
    #1 n = 0;
    while (Stall_ex && n < 100) begin
      step;
      n++;
    end
    chk("mul_stall_cycles", n, 33);
    chk("mult_lo", ALUResult_ex, 32'hFFFFFFEB);
    rd(HL_HI, "mult_hi", 32'hFFFFFFFF);
    issue(MD_DIVU, 32'd100, 32'd7);
    HiLoRd_ex = HL_ALU;
    for (int i = 0; i < 3; i++) begin
      RsData_ex = 32'(i * 16); RtData_ex = 32'd1;
      #1 chk("add_nostall", Stall_ex, 1'b0);
      chk("add_res", ALUResult_ex, 32'(i * 16 + 1));
      chk("add_busy", MDBusy, 1'b1);
      step;
    end
    wait_idle("divu_done");
    rd(HL_HI, "divu_hi", 32'd2);
    rd(HL_LO, "divu_lo", 32'd14);
    issue(MD_DIV, 32'hFFFFFFF9, 32'd2);
    wait_idle("div_done");
    rd(HL_LO, "div_lo", 32'hFFFFFFFD);
    rd(HL_HI, "div_hi", 32'hFFFFFFFF);
    issue(MD_DIV, 32'd5, 32'd0);
    wait_idle("div0_done");
    rd(HL_LO, "div0_lo", 32'hFFFFFFFF);
    rd(HL_HI, "div0_hi", 32'd5);
    issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_idle("divmin_done");
    rd(HL_LO, "divmin_lo", 32'h80000000);
    rd(HL_HI, "divmin_hi", 32'h0);
    issue(MD_MULTU, 32'hFFFFFFFF, 32'd2);
    wait_idle("multu_done");
    rd(HL_HI, "multu_hi", 32'd1);
    rd(HL_LO, "multu_lo", 32'hFFFFFFFE);
    MDOp_ex = MD_MTLO; HiLoRd_ex = HL_ALU; RsData_ex = 32'h1234;
    #1 chk("mtlo_nostall", Stall_ex, 1'b0);
    step;
    rd(HL_LO, "mflo_after_mtlo", 32'h1234);
    chk("mflo_nostall", Stall_ex, 1'b0);
    MDOp_ex = MD_MTHI; HiLoRd_ex = HL_ALU; RsData_ex = 32'hABCD;
    step;
    rd(HL_HI, "mfhi_after_mthi", 32'hABCD);
    issue(MD_MULT, 32'd2, 32'd3);
    MDOp_ex = MD_MULT; RsData_ex = 32'd4; RtData_ex = 32'd5;
    #1 n = 0;
    while (Stall_ex && n < 100) begin
      step;
      n++;
    end
    chk("mul2_stall_cycles", n, 33);
    chk("mul2_busy_clear", MDBusy, 1'b0);
    step;
    MDOp_ex = MD_NONE; HiLoRd_ex = HL_LO;
    #1 chk("mul2_started", Stall_ex, 1'b1);
    wait_idle("mul2_done");
    rd(HL_LO, "mul2_lo", 32'd20);
    issue(MD_MULT, 32'd6, 32'd7);
    HiLoRd_ex = HL_LO;
    repeat (9) step;
    #1 chk("pre_rst_stall", Stall_ex, 1'b1);
    reset = 1'b1;
    #1 chk("async_busy", MDBusy, 1'b0);
    chk("async_stall", Stall_ex, 1'b0);
    step;
    reset = 1'b0;
    rd(HL_LO, "rst_mid_lo", 32'h0);
    rd(HL_HI, "rst_mid_hi", 32'h0);
    issue(MD_MULT, 32'd6, 32'd7);
    wait_idle("post_rst_done");
    rd(HL_LO, "post_rst_lo", 32'd42);
    rd(HL_HI, "post_rst_hi", 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
